// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_port_arbiter
//  Description : Shares the single SDRAM controller port between port 0
//                (MCD212 display/CPU, burst capable) and port 1 (CDIC sector
//                DMA, single word). One pending request latched per port,
//                fixed priority to port 0 with a starvation limit, periodic
//                refresh scheduled ahead of new grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
   parameter int REFRESH_INTERVAL = 234,
   parameter int STARVE_LIMIT     = 8
) (
   input  logic        clk30,
   input  logic        reset,
   // port 0
   input  logic [24:0] p0_addr,
   input  logic        p0_rd,
   input  logic        p0_wr,
   input  logic        p0_word,
   input  logic [15:0] p0_din,
   input  logic        p0_burst,
   output logic [15:0] p0_dout,
   output logic        p0_busy,
   output logic        p0_burstdata_valid,
   // port 1
   input  logic [24:0] p1_addr,
   input  logic        p1_rd,
   input  logic        p1_wr,
   input  logic        p1_word,
   input  logic [15:0] p1_din,
   output logic [15:0] p1_dout,
   output logic        p1_busy,
   // SDRAM controller
   output logic [24:0] sdram_addr,
   output logic        sdram_rd,
   output logic        sdram_wr,
   output logic        sdram_word,
   output logic        sdram_burst,
   output logic        sdram_refresh,
   output logic [15:0] sdram_din,
   input  logic [15:0] sdram_dout,
   input  logic        sdram_busy,
   input  logic        sdram_burstdata_valid
);

   localparam int c_REF_W = $clog2(REFRESH_INTERVAL + 1);
   localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_GUARD     = 3'd2,
      S_WAIT      = 3'd3,
      S_REF_ISSUE = 3'd4,
      S_REF_GUARD = 3'd5,
      S_REF_WAIT  = 3'd6
   } state_t;

   state_t               r_state;
   logic [c_REF_W-1:0]   r_ref_cnt;
   logic                 r_ref_due;
   logic [c_STV_W-1:0]   r_starve;
   logic                 r_gnt;          // 0 = port 0 owns the access, 1 = port 1

   logic                 r_pend0, r_pend1;
   logic [24:0]          r_addr0, r_addr1;
   logic                 r_word0, r_word1;
   logic [15:0]          r_din0,  r_din1;
   logic                 r_wr0,   r_wr1;
   logic                 r_burst0;

   logic [15:0]          r_p0_dout, r_p1_dout;
   logic [24:0]          r_sdram_addr;
   logic [15:0]          r_sdram_din;
   logic                 r_sdram_rd, r_sdram_wr, r_sdram_word;
   logic                 r_sdram_burst, r_sdram_refresh;

   logic                 w_acc0, w_acc1;
   logic                 w_ref_tc;
   logic                 w_pick1;
   logic                 w_burst_act;

   // A strobe is only taken when that port has nothing outstanding
   assign w_acc0   = (p0_rd | p0_wr) & ~r_pend0;
   assign w_acc1   = (p1_rd | p1_wr) & ~r_pend1;
   assign w_ref_tc = (r_ref_cnt == c_REF_W'(REFRESH_INTERVAL - 1));
   // Port 1 wins only when port 0 is idle or port 1 has waited out the limit
   assign w_pick1  = r_pend1 & (~r_pend0 | (r_starve == c_STV_W'(STARVE_LIMIT)));
   // Burst data streams straight through while port 0's burst read is in flight
   assign w_burst_act = (r_state == S_GUARD || r_state == S_WAIT) & ~r_gnt & r_sdram_burst;

   // Pending stays set until completion, so it also covers the in-flight phase
   assign p0_busy            = r_pend0;
   assign p1_busy            = r_pend1;
   assign p0_dout            = w_burst_act ? sdram_dout : r_p0_dout;
   assign p0_burstdata_valid = w_burst_act & sdram_burstdata_valid;
   assign p1_dout            = r_p1_dout;
   assign sdram_addr         = r_sdram_addr;
   assign sdram_din          = r_sdram_din;
   assign sdram_rd           = r_sdram_rd;
   assign sdram_wr           = r_sdram_wr;
   assign sdram_word         = r_sdram_word;
   assign sdram_burst        = r_sdram_burst;
   assign sdram_refresh      = r_sdram_refresh;

   // Free-running refresh interval counter
   always_ff @(posedge clk30) begin
      if (reset)         r_ref_cnt <= '0;
      else if (w_ref_tc) r_ref_cnt <= '0;
      else               r_ref_cnt <= r_ref_cnt + 1'b1;
   end

   // Capture port-0 request fields; rd+wr together is a write, bursts are reads only
   always_ff @(posedge clk30) begin
      if (reset) begin
         r_addr0 <= '0; r_word0 <= 1'b0; r_din0 <= '0; r_wr0 <= 1'b0; r_burst0 <= 1'b0;
      end else if (w_acc0) begin
         r_addr0  <= p0_addr;
         r_word0  <= p0_word;
         r_din0   <= p0_din;
         r_wr0    <= p0_wr;
         r_burst0 <= p0_burst & ~p0_wr;
      end
   end

   // Capture port-1 request fields
   always_ff @(posedge clk30) begin
      if (reset) begin
         r_addr1 <= '0; r_word1 <= 1'b0; r_din1 <= '0; r_wr1 <= 1'b0;
      end else if (w_acc1) begin
         r_addr1 <= p1_addr;
         r_word1 <= p1_word;
         r_din1  <= p1_din;
         r_wr1   <= p1_wr;
      end
   end

   // Arbitration FSM: grants, refresh scheduling and registered controller strobes
   always_ff @(posedge clk30) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pend0 <= 1'b0; r_pend1 <= 1'b0;
         r_gnt <= 1'b0; r_starve <= '0; r_ref_due <= 1'b0;
         r_sdram_rd <= 1'b0; r_sdram_wr <= 1'b0; r_sdram_refresh <= 1'b0;
         r_sdram_addr <= '0; r_sdram_din <= '0; r_sdram_word <= 1'b0; r_sdram_burst <= 1'b0;
         r_p0_dout <= '0; r_p1_dout <= '0;
      end else begin
         r_sdram_rd      <= 1'b0;
         r_sdram_wr      <= 1'b0;
         r_sdram_refresh <= 1'b0;
         if (w_acc0)   r_pend0   <= 1'b1;
         if (w_acc1)   r_pend1   <= 1'b1;
         if (w_ref_tc) r_ref_due <= 1'b1;
         if (!r_pend1) r_starve  <= '0;
         case (r_state)
            S_IDLE: begin
               if (r_ref_due) begin
                  // an expiry landing on this very cycle re-arms the next refresh
                  r_ref_due       <= w_ref_tc;
                  r_sdram_refresh <= 1'b1;
                  r_state         <= S_REF_ISSUE;
               end else if (!sdram_busy && (r_pend0 || r_pend1)) begin
                  r_state <= S_ISSUE;
                  if (w_pick1) begin
                     r_gnt         <= 1'b1;
                     r_starve      <= '0;
                     r_sdram_addr  <= r_addr1;
                     r_sdram_word  <= r_word1;
                     r_sdram_din   <= r_din1;
                     r_sdram_burst <= 1'b0;
                     r_sdram_rd    <= ~r_wr1;
                     r_sdram_wr    <= r_wr1;
                  end else begin
                     r_gnt         <= 1'b0;
                     if (r_pend1) r_starve <= r_starve + 1'b1;
                     r_sdram_addr  <= r_addr0;
                     r_sdram_word  <= r_word0;
                     r_sdram_din   <= r_din0;
                     r_sdram_burst <= r_burst0;
                     r_sdram_rd    <= ~r_wr0;
                     r_sdram_wr    <= r_wr0;
                  end
               end
            end
            S_ISSUE:     r_state <= S_GUARD;
            // controller busy is not yet valid for the new access here
            S_GUARD:     r_state <= S_WAIT;
            S_WAIT: begin
               if (!sdram_busy) begin
                  if (r_gnt) begin
                     if (!r_wr1) r_p1_dout <= sdram_dout;
                     r_pend1 <= 1'b0;
                  end else begin
                     if (!r_wr0) r_p0_dout <= sdram_dout;
                     r_pend0 <= 1'b0;
                  end
                  r_state <= S_IDLE;
               end
            end
            S_REF_ISSUE: r_state <= S_REF_GUARD;
            S_REF_GUARD: r_state <= S_REF_WAIT;
            S_REF_WAIT:  if (!sdram_busy) r_state <= S_IDLE;
            default:     r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_port_arbiter
//  Description : Directed self-checking bench for sdram_port_arbiter with a
//                small reactive SDRAM-controller busy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

   logic        clk30 = 1'b0;
   logic        reset;
   logic [24:0] p0_addr, p1_addr;
   logic        p0_rd, p0_wr, p0_word, p0_burst, p1_rd, p1_wr, p1_word;
   logic [15:0] p0_din, p1_din, p0_dout, p1_dout;
   logic        p0_busy, p1_busy, p0_burstdata_valid;
   logic [24:0] sdram_addr;
   logic        sdram_rd, sdram_wr, sdram_word, sdram_burst, sdram_refresh;
   logic [15:0] sdram_din, sdram_dout;
   logic        sdram_busy, sdram_burstdata_valid;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rst_cyc;

   // controller model controls
   int lat     = 0;
   bit tail_en = 1'b0;
   int rem     = 0;
   bit tl      = 1'b0;

   sdram_port_arbiter #(.REFRESH_INTERVAL(234), .STARVE_LIMIT(8)) dut (
      .clk30(clk30), .reset(reset),
      .p0_addr(p0_addr), .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_word(p0_word),
      .p0_din(p0_din), .p0_burst(p0_burst), .p0_dout(p0_dout), .p0_busy(p0_busy),
      .p0_burstdata_valid(p0_burstdata_valid),
      .p1_addr(p1_addr), .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_word(p1_word),
      .p1_din(p1_din), .p1_dout(p1_dout), .p1_busy(p1_busy),
      .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_wr(sdram_wr),
      .sdram_word(sdram_word), .sdram_burst(sdram_burst), .sdram_refresh(sdram_refresh),
      .sdram_din(sdram_din), .sdram_dout(sdram_dout), .sdram_busy(sdram_busy),
      .sdram_burstdata_valid(sdram_burstdata_valid)
   );

   always #5 clk30 = ~clk30;

   always @(posedge clk30) cyc <= cyc + 1;

   // Controller busy: high for 'lat' cycles starting at the strobe cycle,
   // optionally one extra busy cycle right after the completion cycle
   always @(negedge clk30) begin : model
      bit b;
      b = 1'b0;
      if (reset) begin
         rem = 0; tl = 1'b0;
      end else if (sdram_rd || sdram_wr || sdram_refresh) begin
         rem = lat;
      end else if (rem > 0) begin
         rem = rem - 1;
         if (rem == 0) tl = tail_en;
      end else if (tl) begin
         tl = 1'b0; b = 1'b1;
      end
      sdram_busy = (rem > 0) || b;
   end

   task automatic tick();
      @(negedge clk30);
   endtask

   task automatic wait_refresh(output int t);
      bit seen;
      seen = 1'b0; t = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         tick();
         if (sdram_refresh === 1'b1) begin seen = 1'b1; t = cyc; end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL refresh_timeout actual=none required=pulse within 300"); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({sdram_rd, sdram_wr, sdram_refresh, sdram_burst, sdram_word, p0_busy, p1_busy, p0_burstdata_valid} !== 8'h00) begin
         errors++; $display("FAIL reset_flags actual=%b required=00000000",
            {sdram_rd, sdram_wr, sdram_refresh, sdram_burst, sdram_word, p0_busy, p1_busy, p0_burstdata_valid});
      end
      checks++;
      if ({p0_dout, p1_dout, sdram_din} !== 48'h0) begin
         errors++; $display("FAIL reset_data actual=%h required=0", {p0_dout, p1_dout, sdram_din});
      end
      checks++;
      if (sdram_addr !== 25'h0) begin errors++; $display("FAIL reset_addr actual=%h required=0", sdram_addr); end
      reset   = 1'b0;
      rst_cyc = cyc;
   endtask

   task automatic test_refresh_interval();
      int t1, t2;
      lat = 0;
      wait_refresh(t1);
      checks++;
      if (t1 - rst_cyc !== 235) begin errors++; $display("FAIL refresh_first actual=%0d required=235", t1 - rst_cyc); end
      tick();
      checks++;
      if (sdram_refresh !== 1'b0) begin errors++; $display("FAIL refresh_width actual=%b required=0", sdram_refresh); end
      wait_refresh(t2);
      checks++;
      if (t2 - t1 !== 234) begin errors++; $display("FAIL refresh_period actual=%0d required=234", t2 - t1); end
      repeat (4) tick();
   endtask

   task automatic test_single_read();
      int n, d;
      lat = 3;
      sdram_dout = 16'hBEEF;
      p1_addr = 25'h000100; p1_word = 1'b1; p1_rd = 1'b1;
      n = cyc;
      tick(); p1_rd = 1'b0;
      checks++;
      if (p1_busy !== 1'b1) begin errors++; $display("FAIL p1_busy_rise actual=%b required=1", p1_busy); end
      tick();
      checks++;
      if ({sdram_rd, sdram_wr, sdram_burst, sdram_word, sdram_addr} !== {4'b1001, 25'h000100}) begin
         errors++; $display("FAIL p1_issue actual=%b_%h required=1001_000100",
            {sdram_rd, sdram_wr, sdram_burst, sdram_word}, sdram_addr);
      end
      tick();
      checks++;
      if (sdram_rd !== 1'b0) begin errors++; $display("FAIL p1_rd_width actual=%b required=0", sdram_rd); end
      d = -1;
      for (int i = 0; i < 20 && d < 0; i++) begin
         tick();
         if (p1_busy === 1'b0) d = cyc;
      end
      checks++;
      if (d - n !== 6) begin errors++; $display("FAIL p1_done_cycle actual=%0d required=6", d - n); end
      checks++;
      if (p1_dout !== 16'hBEEF) begin errors++; $display("FAIL p1_dout actual=%h required=beef", p1_dout); end
   endtask

   task automatic test_min_latency();
      int strobes;
      lat = 0;
      p0_addr = 25'h0ABCDE; p0_din = 16'h1234; p0_word = 1'b0; p0_wr = 1'b1;
      tick(); p0_wr = 1'b0;
      tick();
      checks++;
      if ({sdram_wr, sdram_rd, sdram_word, sdram_din, sdram_addr} !== {3'b100, 16'h1234, 25'h0ABCDE}) begin
         errors++; $display("FAIL p0_wr_issue actual=%b_%h_%h required=100_1234_0abcde",
            {sdram_wr, sdram_rd, sdram_word}, sdram_din, sdram_addr);
      end
      // strobe while busy must be dropped
      p0_rd = 1'b1; p0_addr = 25'h000001;
      tick(); p0_rd = 1'b0;
      tick();
      checks++;
      if (p0_busy !== 1'b1) begin errors++; $display("FAIL p0_busy_hold actual=%b required=1", p0_busy); end
      tick();
      checks++;
      if (p0_busy !== 1'b0) begin errors++; $display("FAIL p0_min_latency actual=%b required=0", p0_busy); end
      strobes = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (sdram_rd || sdram_wr || p0_busy) strobes++;
      end
      checks++;
      if (strobes !== 0) begin errors++; $display("FAIL ignored_strobe actual=%0d required=0", strobes); end
   endtask

   task automatic test_simultaneous();
      logic [1:0] exp;
      lat = 2;
      sdram_dout = 16'hCAFE;
      p0_addr = 25'h0000A0; p0_din = 16'h5A5A; p0_word = 1'b1; p0_wr = 1'b1;
      p1_addr = 25'h000200; p1_rd = 1'b1;
      tick(); p0_wr = 1'b0; p1_rd = 1'b0;
      for (int k = 2; k <= 8; k++) begin
         tick();
         exp = (k == 2) ? 2'b01 : (k == 6) ? 2'b10 : 2'b00;
         checks++;
         if ({sdram_rd, sdram_wr} !== exp) begin
            errors++; $display("FAIL simul_strobe_k%0d actual=%b required=%b", k, {sdram_rd, sdram_wr}, exp);
         end
         if (k == 6) begin
            checks++;
            if (sdram_addr !== 25'h000200) begin errors++; $display("FAIL simul_p1_addr actual=%h required=000200", sdram_addr); end
         end
      end
      tick();
      checks++;
      if ({p0_busy, p1_busy, p1_dout} !== {2'b00, 16'hCAFE}) begin
         errors++; $display("FAIL simul_done actual=%b_%h required=00_cafe", {p0_busy, p1_busy}, p1_dout);
      end
   endtask

   task automatic test_starvation();
      int t, nwr, drained;
      bit got;
      wait_refresh(t);
      repeat (4) tick();
      lat = 2; tail_en = 1'b1;
      p0_addr = 25'h000040; p0_din = 16'h0F0F; p0_wr = 1'b1;
      p1_addr = 25'h000444; p1_rd = 1'b1;
      tick(); p1_rd = 1'b0;
      nwr = 0; got = 1'b0;
      for (int i = 0; i < 150 && !got; i++) begin
         tick();
         if (sdram_wr === 1'b1) nwr++;
         if (sdram_rd === 1'b1) begin
            got = 1'b1;
            checks++;
            if (sdram_addr !== 25'h000444) begin errors++; $display("FAIL starve_p1_addr actual=%h required=000444", sdram_addr); end
         end
      end
      p0_wr = 1'b0;
      checks++;
      if (!got || nwr !== 8) begin errors++; $display("FAIL starve_count actual=%0d (p1 granted=%b) required=8", nwr, got); end
      drained = 0;
      for (int i = 0; i < 40 && drained == 0; i++) begin
         tick();
         if (!p0_busy && !p1_busy) drained = 1;
      end
      tail_en = 1'b0;
      checks++;
      if (drained !== 1) begin errors++; $display("FAIL starve_drain actual=busy required=idle"); end
   endtask

   task automatic test_burst();
      int t, pulses, n;
      bit v;
      logic [15:0] d;
      wait_refresh(t);
      repeat (4) tick();
      lat = 8;
      sdram_dout = 16'h5555; sdram_burstdata_valid = 1'b0;
      p0_addr = 25'h001000; p0_word = 1'b1; p0_burst = 1'b1; p0_rd = 1'b1;
      n = cyc;
      tick(); p0_rd = 1'b0; p0_burst = 1'b0;
      tick();
      checks++;
      if ({sdram_rd, sdram_burst} !== 2'b11) begin errors++; $display("FAIL burst_issue actual=%b required=11", {sdram_rd, sdram_burst}); end
      pulses = 0;
      for (int k = 3; k <= 10; k++) begin
         tick();
         v = (k == 3 || k == 5 || k == 6 || k == 8);
         d = v ? (16'hA000 + 16'(k)) : ((k == 10) ? 16'hD00D : 16'h5555);
         sdram_burstdata_valid = v; sdram_dout = d;
         #1;
         if (p0_burstdata_valid === 1'b1) pulses++;
         checks++;
         if ({p0_burstdata_valid, p0_dout} !== {v, d}) begin
            errors++; $display("FAIL burst_k%0d actual=%b_%h required=%b_%h", k, p0_burstdata_valid, p0_dout, v, d);
         end
      end
      checks++;
      if (pulses !== 4) begin errors++; $display("FAIL burst_pulses actual=%0d required=4", pulses); end
      tick();
      sdram_burstdata_valid = 1'b1; sdram_dout = 16'h7777;
      #1;
      checks++;
      if ({p0_busy, p0_burstdata_valid, p0_dout} !== {2'b00, 16'hD00D}) begin
         errors++; $display("FAIL burst_after actual=%b_%h required=00_d00d", {p0_busy, p0_burstdata_valid}, p0_dout);
      end
      sdram_burstdata_valid = 1'b0;
   endtask

   task automatic test_refresh_defer();
      int t, early, c1, rdc;
      bit done;
      wait_refresh(t);
      repeat (4) tick();
      lat = 300;
      p0_addr = 25'h002000; p0_burst = 1'b1; p0_rd = 1'b1;
      p1_addr = 25'h000300; p1_rd = 1'b1;
      tick(); p0_rd = 1'b0; p0_burst = 1'b0; p1_rd = 1'b0;
      early = 0; done = 1'b0; c1 = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         tick();
         if (sdram_refresh === 1'b1) early++;
         if (p0_busy === 1'b0) begin done = 1'b1; c1 = cyc; end
      end
      lat = 2;
      checks++;
      if (!done || early !== 0) begin errors++; $display("FAIL defer_during_wait actual=%0d (done=%b) required=0", early, done); end
      tick();
      checks++;
      if ({sdram_refresh, sdram_rd, p1_busy} !== 3'b101) begin
         errors++; $display("FAIL defer_ref_first actual=%b required=101", {sdram_refresh, sdram_rd, p1_busy});
      end
      rdc = -1;
      for (int i = 0; i < 20 && rdc < 0; i++) begin
         tick();
         if (sdram_rd === 1'b1) rdc = cyc;
      end
      checks++;
      if (rdc - c1 !== 5 || sdram_addr !== 25'h000300) begin
         errors++; $display("FAIL defer_p1_after actual=%0d_%h required=5_000300", rdc - c1, sdram_addr);
      end
      repeat (6) tick();
   endtask

   task automatic test_reset_wait();
      int t, strobes;
      wait_refresh(t);
      repeat (4) tick();
      lat = 20;
      p1_addr = 25'h000500; p1_rd = 1'b1;
      tick(); p1_rd = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      checks++;
      if ({sdram_rd, sdram_wr, sdram_refresh, sdram_burst, p0_busy, p1_busy, p0_burstdata_valid} !== 7'h00) begin
         errors++; $display("FAIL rst_wait_flags actual=%b required=0000000",
            {sdram_rd, sdram_wr, sdram_refresh, sdram_burst, p0_busy, p1_busy, p0_burstdata_valid});
      end
      checks++;
      if ({p0_dout, p1_dout, sdram_addr} !== 57'h0) begin
         errors++; $display("FAIL rst_wait_data actual=%h_%h_%h required=0", p0_dout, p1_dout, sdram_addr);
      end
      reset = 1'b0;
      strobes = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (sdram_rd || sdram_wr || sdram_refresh || p1_busy) strobes++;
      end
      checks++;
      if (strobes !== 0) begin errors++; $display("FAIL rst_wait_quiet actual=%0d required=0", strobes); end
   endtask

   initial begin
      reset = 1'b1;
      p0_addr = '0; p0_rd = 1'b0; p0_wr = 1'b0; p0_word = 1'b0; p0_din = '0; p0_burst = 1'b0;
      p1_addr = '0; p1_rd = 1'b0; p1_wr = 1'b0; p1_word = 1'b0; p1_din = '0;
      sdram_dout = '0; sdram_busy = 1'b0; sdram_burstdata_valid = 1'b0;
      test_reset();
      test_refresh_interval();
      test_single_read();
      test_min_latency();
      test_simultaneous();
      test_starvation();
      test_burst();
      test_refresh_defer();
      test_reset_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
